// File: rtl/rr_sel_arb_32.sv
// rtl/rr_sel_arb_32.sv - 32-way round-robin arbiter producing a registered mux select
module rr_sel_arb_32 #(
    parameter int N_REQ = 32,
    parameter int IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic                 gnt_ack,
    input  logic                 flush,
    output logic                 gnt_vld,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic [N_REQ-1:0]     gnt_oh,
    output logic [IDX_W-1:0]     ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   base_ptr;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   win;
    logic               any_req;
    logic               acked;

    // On ack the search starts just past the current winner, so the winner scans last.
    always_comb begin
        acked    = (state == GRANT) && gnt_ack;
        base_ptr = acked ? gnt_idx + 5'd1 : ptr;
        req_dbl  = {req, req} >> base_ptr;
        req_rot  = req_dbl[N_REQ-1:0];
        any_req  = |req;
        win      = base_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win = base_ptr + IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
            gnt_oh  <= '0;
            ptr     <= '0;
        end else if (flush) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt_oh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= GRANT;
                        gnt_vld <= 1'b1;
                        gnt_idx <= win;
                        gnt_oh  <= N_REQ'(1) << win;
                    end
                end
                GRANT: begin
                    if (gnt_ack) begin
                        ptr <= gnt_idx + 5'd1;
                        if (any_req) begin
                            gnt_idx <= win;
                            gnt_oh  <= N_REQ'(1) << win;
                        end else begin
                            state   <= IDLE;
                            gnt_vld <= 1'b0;
                            gnt_oh  <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_vld <= 1'b0;
                    gnt_oh  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_sel_arb_32.sv
// tb/tb_rr_sel_arb_32.sv - scoreboard bench for rr_sel_arb_32
module tb_rr_sel_arb_32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic        gnt_ack;
    logic        flush;
    logic        gnt_vld;
    logic [4:0]  gnt_idx;
    logic [31:0] gnt_oh;
    logic [4:0]  ptr;

    rr_sel_arb_32 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt_ack (gnt_ack),
        .flush   (flush),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt_oh  (gnt_oh),
        .ptr     (ptr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [4:0]  idx;
        logic [4:0]  ptr;
        logic [31:0] oh;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic       m_vld;
    logic [4:0] m_idx;
    logic [4:0] m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [4:0] search(input logic [31:0] r, input logic [4:0] p);
        logic [4:0] j;
        for (int k = 0; k < 32; k++) begin
            j = 5'((int'(p) + k) % 32);
            if (r[j]) return j;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0;
        m_idx = 5'd0;
        m_ptr = 5'd0;
    endtask

    task automatic step(input logic [31:0] r, input logic a, input logic f, input string tag);
        exp_t e;
        exp_t o;
        req     = r;
        gnt_ack = a;
        flush   = f;
        if (f) begin
            m_vld = 1'b0;
        end else if (!m_vld) begin
            if (r != 0) begin
                m_idx = search(r, m_ptr);
                m_vld = 1'b1;
            end
        end else if (a) begin
            m_ptr = m_idx + 5'd1;
            if (r != 0) m_idx = search(r, m_ptr);
            else        m_vld = 1'b0;
        end
        e.vld = m_vld;
        e.idx = m_idx;
        e.ptr = m_ptr;
        e.oh  = m_vld ? (32'd1 << m_idx) : 32'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check({tag, ".vld"}, {31'd0, gnt_vld}, {31'd0, o.vld});
        check({tag, ".idx"}, {27'd0, gnt_idx}, {27'd0, o.idx});
        check({tag, ".ptr"}, {27'd0, ptr},     {27'd0, o.ptr});
        check({tag, ".oh"},  gnt_oh,           o.oh);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        gnt_ack = 1'b0;
        flush   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst.vld", {31'd0, gnt_vld}, 32'd0);
        check("rst.idx", {27'd0, gnt_idx}, 32'd0);
        check("rst.ptr", {27'd0, ptr},     32'd0);
        check("rst.oh",  gnt_oh,           32'd0);
        #2;
        rst = 1'b0;

        // async reset mid-grant on idx 9
        step(32'h0000_0200, 1'b0, 1'b0, "t1.g9");
        #2;
        rst = 1'b1;
        #1;
        check("t1.async.vld", {31'd0, gnt_vld}, 32'd0);
        check("t1.async.idx", {27'd0, gnt_idx}, 32'd0);
        check("t1.async.ptr", {27'd0, ptr},     32'd0);
        check("t1.async.oh",  gnt_oh,           32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(32'd0, 1'b0, 1'b0, "t1.idle");

        // grant held without ack despite new higher-priority requests
        step(32'h0000_0010, 1'b0, 1'b0, "t2.g4");
        for (int i = 0; i < 10; i++) step(32'hFFFF_FFFF, 1'b0, 1'b0, "t2.hold");
        step(32'd0, 1'b1, 1'b0, "t2.rel");

        // full rotation with continuous ack
        do_reset();
        step(32'hFFFF_FFFF, 1'b0, 1'b0, "t3.g0");
        for (int i = 0; i < 32; i++) step(32'hFFFF_FFFF, 1'b1, 1'b0, "t3.rot");
        step(32'd0, 1'b1, 1'b0, "t3.end");

        // wraparound at 31
        step(32'h4000_0000, 1'b0, 1'b0, "t4.g30");
        step(32'd0, 1'b1, 1'b0, "t4.p31");
        step(32'h8000_0001, 1'b0, 1'b0, "t4.g31");
        step(32'h8000_0001, 1'b1, 1'b0, "t4.g0");
        step(32'h8000_0001, 1'b1, 1'b0, "t4.g31b");
        step(32'd0, 1'b1, 1'b0, "t4.end");

        // sole requester re-wins back-to-back
        step(32'h0000_0080, 1'b0, 1'b0, "t5.g7");
        for (int i = 0; i < 4; i++) step(32'h0000_0080, 1'b1, 1'b0, "t5.rewin");
        step(32'd0, 1'b1, 1'b0, "t5.end");
        step(32'd0, 1'b1, 1'b0, "t5.idle_ack");

        // flush overrides ack
        do_reset();
        step(32'h0000_0020, 1'b0, 1'b0, "t6.g5");
        step(32'h0000_0020, 1'b1, 1'b1, "t6.flush");
        step(32'h0000_0020, 1'b0, 1'b0, "t6.regrant");
        step(32'h0000_0060, 1'b1, 1'b0, "t6.next");
        step(32'h0000_0060, 1'b0, 1'b1, "t6.flush2");

        // random traffic against the model
        for (int i = 0; i < 200; i++)
            step($urandom & $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), "rnd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
